// File: rtl/alu_share_arbiter_if.sv
// ----------------------------------------------------------------------------
// alu_share_arbiter_if
// Handshake bundle between the two ALU requesters and alu_share_arbiter.
//   req0_* / req1_* : valid/ready request channel carrying op code and operands
//   rsp0_* / rsp1_* : valid/ready response channel, one per requester
//   rsp_result/zero : shared response payload, qualified by rspN_valid
// Modports:
//   slave  - arbiter side (consumes requests, produces responses)
//   master - requester side
// ----------------------------------------------------------------------------
interface alu_share_arbiter_if #(
    parameter int WIDTH = 32
);
    logic             req0_valid;
    logic             req0_ready;
    logic [3:0]       req0_op;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;

    logic             req1_valid;
    logic             req1_ready;
    logic [3:0]       req1_op;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;

    logic             rsp0_valid;
    logic             rsp0_ready;
    logic             rsp1_valid;
    logic             rsp1_ready;
    logic [WIDTH-1:0] rsp_result;
    logic             rsp_zero;

    modport slave (
        input  req0_valid, req0_op, req0_a, req0_b,
        input  req1_valid, req1_op, req1_a, req1_b,
        output req0_ready, req1_ready,
        output rsp0_valid, rsp1_valid, rsp_result, rsp_zero,
        input  rsp0_ready, rsp1_ready
    );

    modport master (
        output req0_valid, req0_op, req0_a, req0_b,
        output req1_valid, req1_op, req1_a, req1_b,
        input  req0_ready, req1_ready,
        input  rsp0_valid, rsp1_valid, rsp_result, rsp_zero,
        output rsp0_ready, rsp1_ready
    );
endinterface

// File: rtl/alu_share_arbiter.sv
// ----------------------------------------------------------------------------
// alu_share_arbiter
// Shares one WIDTH-bit ALU between requester 0 (core datapath) and
// requester 1 (auxiliary unit) with round-robin arbitration.
// Flow: IDLE (grant) -> EXEC (ALU inputs held ALU_LAT cycles) -> RESP
// (result held until the winner takes it) -> IDLE.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   bus (slave)       request/response handshakes, see alu_share_arbiter_if
//   alu_a/alu_b/alu_op  registered operands/op code to the ALU
//   alu_result/alu_zero result from the ALU, captured on last EXEC cycle
//   busy              high whenever not IDLE
//   perf_grant0/1     saturating grant counters (ALU_ARB_PERF_EN only)
// Optional feature macro: ALU_ARB_PERF_EN
// ----------------------------------------------------------------------------
module alu_share_arbiter #(
    parameter int WIDTH   = 32,
    parameter int ALU_LAT = 1,
    parameter int CNT_W   = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    alu_share_arbiter_if.slave   bus,
    output logic [WIDTH-1:0]     alu_a,
    output logic [WIDTH-1:0]     alu_b,
    output logic [3:0]           alu_op,
    input  logic [WIDTH-1:0]     alu_result,
    input  logic                 alu_zero,
    output logic                 busy
`ifdef ALU_ARB_PERF_EN
    ,
    output logic [CNT_W-1:0]     perf_grant0,
    output logic [CNT_W-1:0]     perf_grant1
`endif
);

    localparam int CW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(ALU_LAT - 1);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             last_grant_q, last_grant_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [3:0]       op_q, op_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             zero_q, zero_d;
    logic             grant0, grant1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            last_grant_q <= 1'b1;
            a_q          <= '0;
            b_q          <= '0;
            op_q         <= '0;
            res_q        <= '0;
            zero_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_grant_q <= last_grant_d;
            a_q          <= a_d;
            b_q          <= b_d;
            op_q         <= op_d;
            res_q        <= res_d;
            zero_q       <= zero_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        last_grant_d = last_grant_q;
        a_d          = a_q;
        b_d          = b_q;
        op_d         = op_q;
        res_d        = res_q;
        zero_d       = zero_q;
        grant0       = 1'b0;
        grant1       = 1'b0;
        case (state_q)
            IDLE: begin
                // On a tie the requester that did not win last time goes first.
                if (bus.req0_valid && (!bus.req1_valid || last_grant_q))
                    grant0 = 1'b1;
                else if (bus.req1_valid)
                    grant1 = 1'b1;
                if (grant0) begin
                    a_d          = bus.req0_a;
                    b_d          = bus.req0_b;
                    op_d         = bus.req0_op;
                    last_grant_d = 1'b0;
                end else if (grant1) begin
                    a_d          = bus.req1_a;
                    b_d          = bus.req1_b;
                    op_d         = bus.req1_op;
                    last_grant_d = 1'b1;
                end
                if (grant0 || grant1) begin
                    cnt_d   = '0;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                if (cnt_q == CNT_LAST) begin
                    res_d   = alu_result;
                    zero_d  = alu_zero;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            RESP: begin
                // last_grant_q names the owner of the in-flight response.
                if (last_grant_q ? bus.rsp1_ready : bus.rsp0_ready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Ready is a combinational pulse in IDLE so that a requester dropping
    // valid is never granted; rst_n gating keeps it low while in reset.
    assign bus.req0_ready = rst_n & grant0;
    assign bus.req1_ready = rst_n & grant1;
    assign bus.rsp0_valid = (state_q == RESP) & ~last_grant_q;
    assign bus.rsp1_valid = (state_q == RESP) &  last_grant_q;
    assign bus.rsp_result = res_q;
    assign bus.rsp_zero   = zero_q;
    assign alu_a          = a_q;
    assign alu_b          = b_q;
    assign alu_op         = op_q;
    assign busy           = (state_q != IDLE);

`ifdef ALU_ARB_PERF_EN
    logic [CNT_W-1:0] perf0_q, perf1_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf0_q <= '0;
            perf1_q <= '0;
        end else begin
            if (grant0 && (perf0_q != '1)) perf0_q <= perf0_q + CNT_W'(1);
            if (grant1 && (perf1_q != '1)) perf1_q <= perf1_q + CNT_W'(1);
        end
    end

    assign perf_grant0 = perf0_q;
    assign perf_grant1 = perf1_q;
`else
    // CNT_W only sizes the optional counters; this empty block keeps it
    // referenced and marks an illegal configuration.
    if (CNT_W < 1 || ALU_LAT < 1) begin : g_bad_cfg
    end
`endif

endmodule

// File: tb/tb_alu_share_arbiter.sv
module tb_alu_share_arbiter;
    localparam int W    = 32;
    localparam int LAT  = 1;
    localparam int CNTW = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, rst4_n;
    alu_share_arbiter_if #(.WIDTH(W)) bus();
    alu_share_arbiter_if #(.WIDTH(W)) if4();

    logic [W-1:0] alu_a, alu_b, alu_result, alu4_a, alu4_b, alu4_result;
    logic [3:0]   alu_op, alu4_op;
    logic         alu_zero, busy, alu4_zero, busy4;
`ifdef ALU_ARB_PERF_EN
    logic [CNTW-1:0] perf_grant0, perf_grant1, perf4_0, perf4_1;
`endif

    function automatic logic [W-1:0] alu_fn(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        case (op)
            4'b0010: return a + b;
            4'b0110: return a - b;
            4'b0000: return a & b;
            4'b0001: return a | b;
            4'b0111: return W'($signed(a) < $signed(b));
            4'b1100: return ~(a | b);
            default: return a ^ b;
        endcase
    endfunction

    assign alu_result  = alu_fn(alu_op, alu_a, alu_b);
    assign alu_zero    = (alu_result == '0);
    assign alu4_result = alu_fn(alu4_op, alu4_a, alu4_b);
    assign alu4_zero   = (alu4_result == '0);

    alu_share_arbiter #(.WIDTH(W), .ALU_LAT(LAT), .CNT_W(CNTW)) u_dut (
        .clk(clk), .rst_n(rst_n), .bus(bus),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_result(alu_result), .alu_zero(alu_zero), .busy(busy)
`ifdef ALU_ARB_PERF_EN
        , .perf_grant0(perf_grant0), .perf_grant1(perf_grant1)
`endif
    );

    alu_share_arbiter #(.WIDTH(W), .ALU_LAT(4), .CNT_W(CNTW)) u_dut4 (
        .clk(clk), .rst_n(rst4_n), .bus(if4),
        .alu_a(alu4_a), .alu_b(alu4_b), .alu_op(alu4_op),
        .alu_result(alu4_result), .alu_zero(alu4_zero), .busy(busy4)
`ifdef ALU_ARB_PERF_EN
        , .perf_grant0(perf4_0), .perf_grant1(perf4_1)
`endif
    );

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural reference model + per-cycle compare ------
    int          m_wait;       // cycles until the granted op's result is ready
    bit          m_pend;       // a response is waiting to be taken
    bit          m_owner, m_last;
    logic [W-1:0] m_a, m_b, m_res;
    logic [3:0]  m_op;
    bit          m_zero;
    int          m_perf0, m_perf1;
    int          gq[$];
    int          rq_own[$];
    logic [W-1:0] rq_res[$];
    bit          rq_zero[$];

    always @(negedge clk) begin : cmp
        bit idle, e_r0, e_r1;
        if (!rst_n) begin
            m_wait = 0; m_pend = 0; m_last = 1; m_owner = 0;
            m_a = '0; m_b = '0; m_op = '0; m_res = '0; m_zero = 0;
            m_perf0 = 0; m_perf1 = 0;
            chk("rst_req_ready", {bus.req0_ready, bus.req1_ready}, 0);
            chk("rst_rsp_valid", {bus.rsp0_valid, bus.rsp1_valid}, 0);
            chk("rst_busy", busy, 0);
            chk("rst_alu", {alu_a, alu_b, alu_op}, 0);
            chk("rst_rsp", {bus.rsp_result, bus.rsp_zero}, 0);
        end else begin
            idle = (m_wait == 0) && !m_pend;
            e_r0 = idle && bus.req0_valid && (!bus.req1_valid || m_last);
            e_r1 = idle && bus.req1_valid && !e_r0;
            chk("req0_ready", bus.req0_ready, e_r0);
            chk("req1_ready", bus.req1_ready, e_r1);
            chk("rsp0_valid", bus.rsp0_valid, m_pend && !m_owner);
            chk("rsp1_valid", bus.rsp1_valid, m_pend && m_owner);
            chk("busy", busy, !idle);
            chk("alu_a", alu_a, m_a);
            chk("alu_b", alu_b, m_b);
            chk("alu_op", alu_op, m_op);
            chk("rsp_result", bus.rsp_result, m_res);
            chk("rsp_zero", bus.rsp_zero, m_zero);
`ifdef ALU_ARB_PERF_EN
            chk("perf_grant0", perf_grant0, m_perf0);
            chk("perf_grant1", perf_grant1, m_perf1);
`endif
            if (bus.req0_ready) gq.push_back(0);
            if (bus.req1_ready) gq.push_back(1);
            if (bus.rsp0_valid && bus.rsp0_ready) begin
                rq_own.push_back(0); rq_res.push_back(bus.rsp_result); rq_zero.push_back(bus.rsp_zero);
            end
            if (bus.rsp1_valid && bus.rsp1_ready) begin
                rq_own.push_back(1); rq_res.push_back(bus.rsp_result); rq_zero.push_back(bus.rsp_zero);
            end
            if (e_r0 || e_r1) begin
                m_owner = e_r1; m_last = e_r1;
                m_a  = e_r1 ? bus.req1_a  : bus.req0_a;
                m_b  = e_r1 ? bus.req1_b  : bus.req0_b;
                m_op = e_r1 ? bus.req1_op : bus.req0_op;
                m_wait = LAT;
                if (e_r0 && m_perf0 < (1 << CNTW) - 1) m_perf0++;
                if (e_r1 && m_perf1 < (1 << CNTW) - 1) m_perf1++;
            end else if (m_wait > 0) begin
                m_wait--;
                if (m_wait == 0) begin
                    m_pend = 1;
                    m_res  = alu_fn(m_op, m_a, m_b);
                    m_zero = (m_res == '0);
                end
            end else if (m_pend && (m_owner ? bus.rsp1_ready : bus.rsp0_ready)) begin
                m_pend = 0;
            end
        end
    end

    bit watch4 = 0, seen4 = 0;
    always @(negedge clk)
        if (watch4 && (if4.rsp0_valid || if4.rsp1_valid)) seen4 = 1;

    // ---------------- stimulus helpers -------------------------------------
    logic [3:0] ops [6] = '{4'b0010, 4'b0110, 4'b0000, 4'b0001, 4'b0111, 4'b1100};

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic rnd_op(output logic [3:0] op, output logic [W-1:0] a, output logic [W-1:0] b);
        op = ops[$urandom_range(5)];
        a  = $urandom_range(3) == 0 ? W'($urandom_range(3)) : W'($urandom);
        b  = $urandom_range(3) == 0 ? a : W'($urandom);
    endtask

    // waits at most budget negedges for reqN_ready; returns on that negedge
    task automatic wait_ready(input int p, input int budget, output bit ok);
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (p == 0 ? bus.req0_ready : bus.req1_ready) begin ok = 1; break; end
        end
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin : stim
        bit ok, h0, h1;
        int n;
        logic [W-1:0] save;
        rst_n = 0; rst4_n = 0;
        bus.req0_valid = 0; bus.req0_op = 0; bus.req0_a = 0; bus.req0_b = 0;
        bus.req1_valid = 0; bus.req1_op = 0; bus.req1_a = 0; bus.req1_b = 0;
        bus.rsp0_ready = 0; bus.rsp1_ready = 0;
        if4.req0_valid = 0; if4.req0_op = 0; if4.req0_a = 0; if4.req0_b = 0;
        if4.req1_valid = 0; if4.req1_op = 0; if4.req1_a = 0; if4.req1_b = 0;
        if4.rsp0_ready = 0; if4.rsp1_ready = 0;

        // T1: reset with random inputs, then idle
        repeat (3) begin
            tick();
            bus.req0_valid = 1'($urandom); bus.req1_valid = 1'($urandom);
            rnd_op(bus.req0_op, bus.req0_a, bus.req0_b);
            rnd_op(bus.req1_op, bus.req1_a, bus.req1_b);
            bus.rsp0_ready = 1'($urandom); bus.rsp1_ready = 1'($urandom);
        end
        tick();
        bus.req0_valid = 0; bus.req1_valid = 0; bus.rsp0_ready = 0; bus.rsp1_ready = 0;
        rst_n = 1;
        repeat (3) tick();
        @(negedge clk);
        chk("t1_idle_busy", busy, 0);
        chk("t1_idle_ready", {bus.req0_ready, bus.req1_ready}, 0);

        // T2: single op on requester 0
        tick();
        bus.req0_op = 4'b0010; bus.req0_a = 5; bus.req0_b = 7; bus.req0_valid = 1; bus.rsp0_ready = 1;
        wait_ready(0, 10, ok);
        chk("t2_granted", ok, 1);
        tick();
        bus.req0_valid = 0;
        @(negedge clk);
        chk("t2_ready_pulse", bus.req0_ready, 0);
        chk("t2_alu_in", {alu_a, alu_b, alu_op}, {32'd5, 32'd7, 4'b0010});
        chk("t2_rsp_early", bus.rsp0_valid, 0);
        tick();
        @(negedge clk);
        chk("t2_rsp0_valid", bus.rsp0_valid, 1);
        chk("t2_rsp1_valid", bus.rsp1_valid, 0);
        chk("t2_result", {bus.rsp_result, bus.rsp_zero}, {32'd12, 1'b0});
        repeat (3) tick();

        // T3: tie from reset, then strict alternation
        rst_n = 0;
        bus.req0_op = 4'b0110; bus.req0_a = 9; bus.req0_b = 9; bus.req0_valid = 1;
        bus.req1_op = 4'b0010; bus.req1_a = 1; bus.req1_b = 2; bus.req1_valid = 1;
        bus.rsp0_ready = 1; bus.rsp1_ready = 1;
        repeat (2) tick();
        gq.delete(); rq_own.delete(); rq_res.delete(); rq_zero.delete();
        rst_n = 1;
        repeat (20) tick();
        bus.req0_valid = 0; bus.req1_valid = 0;
        repeat (5) tick();
        chk("t3_ngrants", gq.size() >= 6, 1);
        for (int i = 0; i < gq.size(); i++) chk("t3_grant_order", gq[i], i % 2);
        chk("t3_nrsp", rq_own.size() >= 2, 1);
        if (rq_own.size() >= 2) begin
            chk("t3_rsp0", {rq_own[0][0], rq_res[0], rq_zero[0]}, {1'b0, 32'd0, 1'b1});
            chk("t3_rsp1", {rq_own[1][0], rq_res[1], rq_zero[1]}, {1'b1, 32'd3, 1'b0});
        end

        // T4: response backpressure on requester 1
        bus.rsp0_ready = 0; bus.rsp1_ready = 0;
        bus.req1_op = 4'b0001; bus.req1_a = 32'hF0; bus.req1_b = 32'h0F; bus.req1_valid = 1;
        wait_ready(1, 10, ok);
        chk("t4_granted1", ok, 1);
        tick();
        bus.req1_valid = 0;
        bus.req0_op = 4'b0010; bus.req0_a = 1; bus.req0_b = 1; bus.req0_valid = 1;
        ok = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.rsp1_valid) begin ok = 1; break; end
            tick();
        end
        chk("t4_rsp1_seen", ok, 1);
        save = bus.rsp_result;
        chk("t4_result", save, 32'hFF);
        repeat (10) begin
            tick();
            @(negedge clk);
            chk("t4_hold_valid", bus.rsp1_valid, 1);
            chk("t4_hold_result", bus.rsp_result, save);
            chk("t4_no_ready0", bus.req0_ready, 0);
        end
        tick();
        bus.rsp1_ready = 1;
        wait_ready(0, 2, ok);
        chk("t4_regrant", ok, 1);
        tick();
        bus.req0_valid = 0; bus.rsp0_ready = 1;
        repeat (5) tick();

        // Randomized traffic incl. dropped valids, backpressure, reset pulses
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            h0 = bus.req0_valid && bus.req0_ready;
            h1 = bus.req1_valid && bus.req1_ready;
            tick();
            if (h0 || !bus.req0_valid) begin
                bus.req0_valid = ($urandom_range(2) != 0);
                rnd_op(bus.req0_op, bus.req0_a, bus.req0_b);
            end else if ($urandom_range(9) == 0) bus.req0_valid = 0;
            if (h1 || !bus.req1_valid) begin
                bus.req1_valid = ($urandom_range(2) != 0);
                rnd_op(bus.req1_op, bus.req1_a, bus.req1_b);
            end else if ($urandom_range(9) == 0) bus.req1_valid = 0;
            bus.rsp0_ready = ($urandom_range(3) != 0);
            bus.rsp1_ready = ($urandom_range(3) != 0);
            rst_n = ($urandom_range(499) != 0);
        end
        tick();
        rst_n = 1; bus.req0_valid = 0; bus.req1_valid = 0; bus.rsp0_ready = 1; bus.rsp1_ready = 1;
        repeat (5) tick();

`ifdef ALU_ARB_PERF_EN
        // T6: grant counters saturate at all-ones
        rst_n = 0;
        tick();
        rst_n = 1;
        bus.req0_op = 4'b0000; bus.req0_a = 3; bus.req0_b = 6; bus.req0_valid = 1;
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.req0_ready) n++;
            if (n == 5) break;
            tick();
        end
        tick();
        bus.req0_valid = 0;
        repeat (4) tick();
        chk("t6_ngrants", n, 5);
        chk("t6_perf0_sat", perf_grant0, 3);
        chk("t6_perf1", perf_grant1, 0);
`endif

        // T5: reset during the 2nd EXEC cycle (ALU_LAT=4 instance)
        rst4_n = 1;
        tick();
        if4.req0_op = 4'b0010; if4.req0_a = 3; if4.req0_b = 4; if4.req0_valid = 1; if4.rsp0_ready = 1;
        ok = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (if4.req0_ready) begin ok = 1; break; end
        end
        chk("t5_granted0", ok, 1);
        tick();                       // now EXEC cycle 1
        if4.req0_valid = 0;
        tick();                       // now EXEC cycle 2
        chk("t5_busy_before", busy4, 1);
        rst4_n = 0;
        #1;
        chk("t5_busy_rst", busy4, 0);
        chk("t5_alu_rst", {alu4_a, alu4_b, alu4_op}, 0);
        watch4 = 1; seen4 = 0;
        repeat (2) tick();
        rst4_n = 1;
        repeat (8) tick();
        chk("t5_no_rsp", seen4, 0);
        watch4 = 0;
        if4.req1_op = 4'b0110; if4.req1_a = 10; if4.req1_b = 3; if4.req1_valid = 1; if4.rsp1_ready = 1;
        ok = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (if4.req1_ready) begin ok = 1; break; end
        end
        chk("t5_granted1", ok, 1);
        n = 0; ok = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if4.req1_valid = 0;
            n++;
            @(negedge clk);
            if (if4.rsp1_valid) begin ok = 1; break; end
        end
        chk("t5_rsp1_seen", ok, 1);
        chk("t5_latency", n, 5);
        chk("t5_result", {if4.rsp_result, if4.rsp_zero}, {32'd7, 1'b0});
        repeat (3) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
